// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified memory port: IF fetches and MEM loads/stores
// are serialised, held for WAIT_CYCLES cycles, and acknowledged with a one-cycle pulse.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_DM_RUN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    input  logic [SEL_W-1:0]  dm_sel_i,
    output logic [DATA_W-1:0] dm_data_o,
    output logic              dm_ack_o,
    output logic              stall_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [SEL_W-1:0]  mem_sel_o,
    input  logic [DATA_W-1:0] mem_data_i
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, DONE} state_t;

    state_t             state_reg, state_next;
    logic               owner_dm_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [RUN_W-1:0]   dm_run_reg;
    logic [ADDR_W-1:0]  req_addr_reg;
    logic [DATA_W-1:0]  req_data_reg;
    logic               req_we_reg;
    logic [SEL_W-1:0]   req_sel_reg;
    logic [DATA_W-1:0]  if_rdata_reg;
    logic [DATA_W-1:0]  dm_rdata_reg;

    logic grant_if, grant_dm, last_beat, in_gnt;

    assign last_beat = (cnt_reg == CNT_W'(WAIT_CYCLES - 1));
    assign in_gnt    = (state_reg == GNT_IF) || (state_reg == GNT_DM);
    assign stall_o   = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);
    assign if_data_o = if_rdata_reg;
    assign dm_data_o = dm_rdata_reg;

    always_comb begin
        state_next = state_reg;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        if_ack_o   = 1'b0;
        dm_ack_o   = 1'b0;
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_sel_o  = '0;
        case (state_reg)
            IDLE: begin
                // DM wins ties unless it has used up its run while IF waits
                if (dm_req_i && !(if_req_i && dm_run_reg == RUN_W'(MAX_DM_RUN))) begin
                    grant_dm   = 1'b1;
                    state_next = GNT_DM;
                end else if (if_req_i) begin
                    grant_if   = 1'b1;
                    state_next = GNT_IF;
                end
            end
            GNT_IF: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = req_addr_reg;
                mem_data_o = req_data_reg;
                if (last_beat) state_next = DONE;
            end
            GNT_DM: begin
                mem_ce_o   = 1'b1;
                mem_we_o   = req_we_reg;
                mem_addr_o = req_addr_reg;
                mem_data_o = req_data_reg;
                mem_sel_o  = req_we_reg ? req_sel_reg : '0;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                if_ack_o   = ~owner_dm_reg;
                dm_ack_o   = owner_dm_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_dm_reg <= 1'b0;
            cnt_reg      <= '0;
            dm_run_reg   <= '0;
            req_addr_reg <= '0;
            req_data_reg <= '0;
            req_we_reg   <= 1'b0;
            req_sel_reg  <= '0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_dm || grant_if) begin
                owner_dm_reg <= grant_dm;
                req_addr_reg <= grant_dm ? dm_addr_i : if_addr_i;
                req_data_reg <= grant_dm ? dm_data_i : '0;
                req_we_reg   <= grant_dm & dm_we_i;
                req_sel_reg  <= grant_dm ? dm_sel_i : '0;
            end
            if (grant_dm) begin
                if (dm_run_reg != RUN_W'(MAX_DM_RUN)) dm_run_reg <= dm_run_reg + RUN_W'(1);
            end else if (grant_if) begin
                dm_run_reg <= '0;
            end
            if (in_gnt) cnt_reg <= last_beat ? '0 : cnt_reg + CNT_W'(1);
            if (state_reg == GNT_IF && last_beat) if_rdata_reg <= mem_data_i;
            // stores leave the load data register untouched
            if (state_reg == GNT_DM && last_beat && !req_we_reg) dm_rdata_reg <= mem_data_i;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts grant order,
// ack cycle, bus contents and read data; a negedge monitor checks against a queue.
module tb_mem_arbiter;
    localparam int W  = 3;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_data_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] if_data_o, dm_data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic        if_ack_o, dm_ack_o, stall_o, mem_ce_o, mem_we_o;
    logic [3:0]  mem_sel_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .WAIT_CYCLES(W), .MAX_DM_RUN(MR)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
        .dm_sel_i(dm_sel_i), .dm_data_o(dm_data_o), .dm_ack_o(dm_ack_o), .stall_o(stall_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .mem_data_i(mem_data_i)
    );

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  sel;
        int          ack_cyc;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] act_mem [16];
    logic [31:0] ref_mem [16];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          dm_run_m = 0;
    bit          mon_en = 1'b0;
    bit          preload = 1'b1;
    int          ce_cnt = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_dm = '0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h11223344;
        if (i == 4) return 32'h3C010001;
        return 32'hA5000000 | (i * 32'h00010203);
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model behind the port: byte-lane writes, combinational reads
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 16; i++) act_mem[i] <= init_word(i);
        end else if (mem_ce_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel_o[b]) act_mem[mem_addr_o[5:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
        end
    end
    assign mem_data_i = mem_ce_o ? act_mem[mem_addr_o[5:2]] : 32'hBAD0BAD0;

    always @(negedge clk) begin : mon
        txn_t e;
        if (mon_en) begin
            chk("stall", stall_o, (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));
            if (mem_ce_o) begin
                if (exp_q.size() == 0) begin
                    chk("ce_without_request", 1, 0);
                end else begin
                    e = exp_q[0];
                    ce_cnt++;
                    chk("mem_addr", mem_addr_o, e.addr);
                    chk("mem_we", mem_we_o, e.we);
                    chk("mem_sel", mem_sel_o, e.sel);
                    if (e.we) chk("mem_wdata", mem_data_o, e.wdata);
                end
            end else begin
                chk("bus_idle_zero", {mem_we_o, mem_sel_o, mem_addr_o, mem_data_o}, 0);
            end
            if (if_ack_o && dm_ack_o) chk("dual_ack", 1, 0);
            if (if_ack_o || dm_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", {if_ack_o, dm_ack_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", dm_ack_o, e.is_dm);
                    chk("ack_cycle", cyc, e.ack_cyc);
                    chk("ce_cycles", ce_cnt, W);
                    if (!e.is_dm) begin
                        chk("if_data", if_data_o, e.rdata);
                        chk("dm_data_hold", dm_data_o, last_dm);
                        last_if = e.rdata;
                    end else if (!e.we) begin
                        chk("dm_load_data", dm_data_o, e.rdata);
                        chk("if_data_hold", if_data_o, last_if);
                        last_dm = e.rdata;
                    end else begin
                        chk("dm_store_hold", dm_data_o, last_dm);
                    end
                    $display("[TB] cyc %0d %s%s addr %h data %h sel %b", cyc,
                             e.is_dm ? "DM" : "IF", e.we ? " store" : " read", e.addr,
                             e.we ? e.wdata : e.rdata, e.sel);
                end
                ce_cnt = 0;
            end
        end
    end

    // Reference: apply an access in grant order to the abstract memory
    task automatic apply(inout txn_t t, input int ack_at);
        int w;
        w = int'(t.addr[5:2]);
        if (t.we) begin
            for (int b = 0; b < 4; b++)
                if (t.sel[b]) ref_mem[w][8*b +: 8] = t.wdata[8*b +: 8];
        end else begin
            t.rdata = ref_mem[w];
        end
        if (t.is_dm) dm_run_m++;
        else         dm_run_m = 0;
        t.ack_cyc = ack_at;
        exp_q.push_back(t);
    endtask

    task automatic do_round(input bit use_if, input bit use_dm, input bit drop,
                            input logic [31:0] ia, input bit dwe, input logic [31:0] da,
                            input logic [31:0] dd, input logic [3:0] ds);
        txn_t ti, td;
        bit   dm_first, if_done, dm_done;
        int   t;
        @(posedge clk); #1;
        t = cyc;
        if_req_i = use_if; if_addr_i = ia;
        dm_req_i = use_dm; dm_we_i = dwe; dm_addr_i = da; dm_data_i = dd; dm_sel_i = ds;
        ti = '{is_dm: 1'b0, we: 1'b0, addr: ia, wdata: 32'h0, rdata: 32'h0, sel: 4'h0, ack_cyc: 0};
        td = '{is_dm: 1'b1, we: dwe, addr: da, wdata: dd, rdata: 32'h0,
               sel: dwe ? ds : 4'h0, ack_cyc: 0};
        dm_first = use_dm && !(use_if && dm_run_m >= MR);
        if (dm_first) begin
            apply(td, t + W + 1);
            if (use_if) apply(ti, t + 2*W + 3);
        end else begin
            if (use_if) apply(ti, t + W + 1);
            if (use_dm) apply(td, t + 2*W + 3);
        end
        if_done = !use_if;
        dm_done = !use_dm;
        for (int k = 0; k < 60 && !(if_done && dm_done); k++) begin
            if (k == 1 && drop) begin
                if_req_i = 1'b0;
                dm_req_i = 1'b0;
            end
            if (k == 1 && !(use_if && use_dm)) begin
                if_addr_i = $urandom; dm_addr_i = $urandom; dm_data_i = $urandom;
                dm_sel_i = 4'($urandom); dm_we_i = ~dm_we_i;
            end
            @(negedge clk);
            if (if_ack_o) if_done = 1'b1;
            if (dm_ack_o) dm_done = 1'b1;
            @(posedge clk); #1;
            if (if_done) if_req_i = 1'b0;
            if (dm_done) dm_req_i = 1'b0;
        end
        if (!(if_done && dm_done)) begin
            chk("round_timeout", {if_done, dm_done}, 2'b11);
            if_req_i = 1'b0;
            dm_req_i = 1'b0;
            repeat (2 * W + 6) @(posedge clk);
            exp_q.delete();
        end
    endtask

    initial begin
        int t, ce_seen, acks, ack_at, kind;
        logic [31:0] d;
        rst = 1'b1;
        if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
        if_addr_i = 0; dm_addr_i = 0; dm_data_i = 0; dm_sel_i = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_acks", {if_ack_o, dm_ack_o}, 0);
        chk("reset_rdata", {if_data_o, dm_data_o}, 0);
        chk("reset_bus", {mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o}, 0);
        chk("reset_stall", stall_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        preload = 1'b0;

        // Reset in the middle of a store, then the held request is served in full
        @(posedge clk); #1;
        t = cyc;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h8; dm_data_i = 32'hDEADBEEF; dm_sel_i = 4'b0011;
        @(posedge clk); @(negedge clk);
        @(negedge clk);
        chk("abort_pre_ce_we", {mem_ce_o, mem_we_o}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_bus_zero", {mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o}, 0);
        chk("abort_no_ack", dm_ack_o, 0);
        chk("abort_stall", stall_o, 1);
        ce_seen = 0; acks = 0; ack_at = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ce_o) ce_seen++;
            if (dm_ack_o) begin
                acks++;
                ack_at = cyc;
                dm_req_i = 1'b0;
            end
        end
        chk("reissue_ce_cycles", ce_seen, W);
        chk("reissue_ack_count", acks, 1);
        chk("reissue_ack_cycle", ack_at, t + 3 + W + 1);
        ref_mem[2][15:0] = 16'hBEEF;
        dm_run_m = 1;
        mon_en = 1'b1;

        // Directed: load after store, plain fetch, dropped fetch, simultaneous requests
        do_round(0, 1, 0, 32'h0, 0, 32'h8, 32'h12345678, 4'hF);
        do_round(1, 0, 0, 32'h10, 0, 32'h0, 32'h0, 4'h0);
        do_round(1, 0, 1, 32'h10, 0, 32'h0, 32'h0, 4'h0);
        do_round(1, 1, 0, 32'h20, 1, 32'h24, 32'hCAFEF00D, 4'b1010);

        for (int r = 0; r < 160; r++) begin
            kind = $urandom_range(0, 2);
            d = $urandom;
            do_round(kind != 1, kind != 0, (kind != 2) && ($urandom_range(0, 7) == 0),
                     {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom),
                     {26'h0, 4'($urandom_range(0, 15)), 2'b00}, d, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem[%0d]", i), act_mem[i], ref_mem[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
